// File: rtl/d_latch_sync.sv
// ============================================================================
//  Module   : d_latch_sync
//  Brief    : Enable-gated D storage register with true and complement outputs.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module d_latch_sync #(
  parameter int                 WIDTH     = 1,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  input  logic             e,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar
);

  logic [WIDTH-1:0] r_q;

  // Reset outranks enable; with e low the register simply holds.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_q <= RESET_VAL;
    end else if (e) begin
      r_q <= d;
    end
  end

  assign q     = r_q;
  assign q_bar = ~r_q;

endmodule

`default_nettype wire

// File: tb/tb_d_latch_sync.sv
// Self-checking bench for d_latch_sync: a 1-bit instance and an 8-bit instance
// with a non-zero reset value, checked through expected-value queues.
`default_nettype none

module tb_d_latch_sync;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset1, e1;
  logic [0:0] d1, q1, qb1;
  logic       reset8, e8;
  logic [7:0] d8, q8, qb8;

  int passed = 0;
  int total  = 0;

  logic [0:0] exp1_q[$];
  logic [7:0] exp8_q[$];

  d_latch_sync #(.WIDTH(1)) dut1 (
    .clk(clk), .reset(reset1), .d(d1), .e(e1), .q(q1), .q_bar(qb1)
  );

  d_latch_sync #(.WIDTH(8), .RESET_VAL(8'hA5)) dut8 (
    .clk(clk), .reset(reset8), .d(d8), .e(e8), .q(q8), .q_bar(qb8)
  );

  // Drive the 1-bit instance for one edge and record the expected q.
  task automatic drive1(input logic r, input logic en, input logic dd, input logic ex);
    @(negedge clk);
    reset1 = r; e1 = en; d1 = dd;
    exp1_q.push_back(ex);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [0:0] ex;
    for (int i = 0; i < 2; i++) begin
      drive1(1'b0, 1'b1, 1'b1, 1'b0);
      ex = exp1_q.pop_front();
      total++;
      if (q1 !== ex || qb1 !== ~ex)
        $display("FAIL reset[%0d]: q=%b q_bar=%b expected q=%b q_bar=%b", i, q1, qb1, ex, ~ex);
      else passed++;
    end
  endtask

  task automatic test_hold();
    logic [2:0] dpat = 3'b010;
    logic [0:0] ex;
    for (int i = 0; i < 3; i++) begin
      drive1(1'b1, 1'b0, dpat[2-i], 1'b0);
      ex = exp1_q.pop_front();
      total++;
      if (q1 !== ex || qb1 !== ~ex)
        $display("FAIL hold[%0d]: q=%b q_bar=%b expected q=%b q_bar=%b", i, q1, qb1, ex, ~ex);
      else passed++;
    end
  endtask

  task automatic test_load();
    logic [0:0] ex;
    drive1(1'b1, 1'b1, 1'b1, 1'b1);
    drive1(1'b1, 1'b0, 1'b0, 1'b1);
    drive1(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      ex = exp1_q.pop_front();
      total++;
      // Only the most recent edge is observable; earlier entries reflect the same held value.
      if (q1 !== ex || qb1 !== ~ex)
        $display("FAIL load[%0d]: q=%b q_bar=%b expected q=%b q_bar=%b", i, q1, qb1, ex, ~ex);
      else passed++;
    end
  endtask

  task automatic test_reset_priority();
    logic [0:0] ex;
    drive1(1'b0, 1'b1, 1'b1, 1'b0);
    ex = exp1_q.pop_front();
    total++;
    if (q1 !== ex || qb1 !== ~ex)
      $display("FAIL reset_priority: q=%b q_bar=%b expected q=%b q_bar=%b", q1, qb1, ex, ~ex);
    else passed++;
    drive1(1'b1, 1'b1, 1'b1, 1'b1);
    ex = exp1_q.pop_front();
    total++;
    if (q1 !== ex || qb1 !== ~ex)
      $display("FAIL reset_release: q=%b q_bar=%b expected q=%b q_bar=%b", q1, qb1, ex, ~ex);
    else passed++;
  endtask

  task automatic test_transparent();
    logic [4:0] dpat = 5'b10110;
    logic [0:0] ex;
    drive1(1'b1, 1'b0, 1'b0, 1'b1);
    void'(exp1_q.pop_front());
    drive1(1'b0, 1'b0, 1'b0, 1'b0);
    void'(exp1_q.pop_front());
    for (int i = 0; i < 5; i++) begin
      drive1(1'b1, 1'b1, dpat[4-i], dpat[4-i]);
      ex = exp1_q.pop_front();
      total++;
      if (q1 !== ex || qb1 !== ~ex)
        $display("FAIL transparent[%0d]: q=%b q_bar=%b expected q=%b q_bar=%b", i, q1, qb1, ex, ~ex);
      else passed++;
    end
  endtask

  task automatic test_wide_between_edges();
    logic [7:0] ex;
    // Reset with e high and d all-ones must still give the reset value.
    @(negedge clk);
    reset8 = 1'b0; e8 = 1'b1; d8 = 8'hFF;
    exp8_q.push_back(8'hA5);
    @(posedge clk); #1;
    ex = exp8_q.pop_front();
    total++;
    if (q8 !== ex || qb8 !== ~ex)
      $display("FAIL wide_reset: q=%h q_bar=%h expected q=%h q_bar=%h", q8, qb8, ex, ~ex);
    else passed++;

    // Short enable pulse wholly between two rising edges.
    @(negedge clk);
    reset8 = 1'b1; e8 = 1'b0; d8 = 8'h3C;
    #1 e8 = 1'b1;
    #2 e8 = 1'b0;
    exp8_q.push_back(8'hA5);
    @(posedge clk); #1;
    ex = exp8_q.pop_front();
    total++;
    if (q8 !== ex || qb8 !== ~ex)
      $display("FAIL wide_glitch: q=%h q_bar=%h expected q=%h q_bar=%h", q8, qb8, ex, ~ex);
    else passed++;

    @(negedge clk);
    e8 = 1'b1;
    exp8_q.push_back(8'h3C);
    @(posedge clk); #1;
    ex = exp8_q.pop_front();
    total++;
    if (q8 !== ex || qb8 !== ~ex)
      $display("FAIL wide_load: q=%h q_bar=%h expected q=%h q_bar=%h", q8, qb8, ex, ~ex);
    else passed++;

    @(negedge clk);
    e8 = 1'b0; d8 = 8'h00;
    exp8_q.push_back(8'h3C);
    @(posedge clk); #1;
    ex = exp8_q.pop_front();
    total++;
    if (q8 !== ex || qb8 !== ~ex)
      $display("FAIL wide_hold: q=%h q_bar=%h expected q=%h q_bar=%h", q8, qb8, ex, ~ex);
    else passed++;
  endtask

  initial begin
    reset1 = 1'b0; e1 = 1'b0; d1 = 1'b0;
    reset8 = 1'b0; e8 = 1'b0; d8 = 8'h00;
    test_reset();
    test_hold();
    test_load();
    test_reset_priority();
    test_transparent();
    test_wide_between_edges();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/d_latch_sync.md
Name: d_latch_sync

Overview:
Clocked, enable-gated D storage element ("latch" in function: holds its value while disabled, loads while enabled). It has true and complementary outputs and is built as a synchronous register so that it is timing-clean inside single-clock logic. It is a generic leaf cell, used wherever a data value must be captured on an enable and then held.

Parameters:
WIDTH, 1, data width in bits of d, q and q_bar.
RESET_VAL, '0 (WIDTH bits), value loaded into q by reset.

Ports:
clk  input  1  system clock; all state changes on its rising edge.
reset  input  1  synchronous, active-low reset; sampled on rising clk.
d  input  WIDTH  data to capture.
e  input  1  load enable, active-high.
q  output  WIDTH  stored value.
q_bar  output  WIDTH  bitwise complement of q.

Behaviour:
- Single clock domain (clk). No asynchronous paths from d, e or reset to q or q_bar.
- The register q updates only on the rising edge of clk. Priority at each edge, highest first:
  1. reset==0: q <= RESET_VAL, regardless of e and d.
  2. reset==1 and e==1: q <= d, the value sampled at that edge.
  3. reset==1 and e==0: q holds its previous value.
- q_bar is always exactly ~q, driven combinationally from the q register. It never disagrees with q, including during reset and after power-up.
- Latency:
  - d captured at edge N appears on q immediately after edge N (one-cycle latency from the d/e setup).
  - Reset takes effect immediately after the first edge at which reset==0 is sampled.
- Reset release: on the first edge with reset==1, normal priority applies. If e==1 at that edge, d is loaded at that same edge.
- Reset asserted mid-operation: any pending load is discarded and q = RESET_VAL. q stays at RESET_VAL for every edge at which reset==0, even if e==1.
- Changes to d or e between clock edges have no effect on q. Glitches on e between edges are ignored.
- e held at 1 continuously: q tracks d with one-cycle delay ("transparent" mode).
- e held at 0 continuously: q holds indefinitely.
- Before the first reset edge, q is undefined (X in simulation). Benches must apply reset==0 for at least one clk edge before checking outputs.
- Width rules: all WIDTH bits load and reset together. No per-bit enable.

Test Plan:
1. Reset: reset=0, e=1, d=1 for 2 edges -> q=0, q_bar=1 after the first edge and after the second edge.
2. Hold with enable low: reset=1, e=0, then toggle d 0->1->0 across 3 edges -> q stays 0, q_bar stays 1.
3. Load: reset=1, e=1, d=1 at one edge -> q=1, q_bar=0 after that edge. Then e=0, d=0 for 2 edges -> q remains 1.
4. Reset priority over enable: q=1, then reset=0, e=1, d=1 at one edge -> q=0, q_bar=1. Release reset with e=1, d=1 -> q=1 after the release edge.
5. Transparent tracking: e=1, reset=1, d pattern 1,0,1,1,0 on successive edges -> q equals the same pattern delayed one cycle, with q_bar the complement at every cycle.
6. Between-edge insensitivity and WIDTH=8, RESET_VAL=8'hA5:
   - Reset -> q=8'hA5, q_bar=8'h5A.
   - Pulse e high for less than a clock period with no edge inside the pulse, d=8'h3C -> q stays 8'hA5.
   - Then e=1 over an edge -> q=8'h3C, q_bar=8'hC3.
